// File: rtl/drenaje_salidas_pkg.sv
// rtl/drenaje_salidas_pkg.sv - shared constants, state encoding and arbitration helper for the output drain
package drenaje_salidas_pkg;

  localparam int DATA_W   = 6;
  localparam int DEST_BIT = 4;
  localparam int CNT_W    = 8;

  localparam logic D0 = 1'b0;
  localparam logic D1 = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_CAPT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    READ = ST_READ,
    CAPT = ST_CAPT,
    HOLD = ST_HOLD
  } state_t;

  // Round-robin when both sides have data, otherwise whichever side is non-empty.
  function automatic logic pick_src(input logic empty0, input logic empty1, input logic rr_last);
    if (!empty0 && !empty1) begin
      return ~rr_last;
    end
    return empty0 ? D1 : D0;
  endfunction

endpackage

// File: rtl/drenaje_salidas_contador.sv
// rtl/drenaje_salidas_contador.sv - saturating up-counter with increment enable
module contador_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/drenaje_salidas.sv
// rtl/drenaje_salidas.sv - round-robin drain of the D0/D1 output FIFOs onto one valid/ready stream
module drenaje_salidas
  import drenaje_salidas_pkg::*;
#(
  parameter int DATA_W   = drenaje_salidas_pkg::DATA_W,
  parameter int DEST_BIT = drenaje_salidas_pkg::DEST_BIT,
  parameter int CNT_W    = drenaje_salidas_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              empty_d0,
  input  logic              empty_d1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count_d0,
  output logic [CNT_W-1:0]  count_d1,
  output logic              misroute_err
);

  state_t            state;
  state_t            state_nxt;
  logic              sel;
  logic              rr_last;
  logic              start;
  logic [DATA_W-1:0] rd_data;

  assign start   = enable && !(empty_d0 && empty_d1);
  assign rd_data = (sel == D1) ? data_out1 : data_out0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      sel          <= D0;
      rr_last      <= D1;
      out_data     <= '0;
      out_src      <= 1'b0;
      out_valid    <= 1'b0;
      misroute_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            sel <= pick_src(empty_d0, empty_d1, rr_last);
          end
        end
        READ: rr_last <= sel;
        CAPT: begin
          out_data  <= rd_data;
          out_src   <= sel;
          out_valid <= 1'b1;
          if (rd_data[DEST_BIT] != sel) begin
            misroute_err <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pops are Moore outputs of READ, so a strobe lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    pop_D0    = 1'b0;
    pop_D1    = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = READ;
      READ: begin
        pop_D0    = (sel == D0);
        pop_D1    = (sel == D1);
        state_nxt = CAPT;
      end
      CAPT: state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  contador_sat #(.W(CNT_W)) u_count_d0 (
    .clk    (clk),
    .resetn (reset),
    .inc    ((state == CAPT) && (sel == D0)),
    .count  (count_d0)
  );

  contador_sat #(.W(CNT_W)) u_count_d1 (
    .clk    (clk),
    .resetn (reset),
    .inc    ((state == CAPT) && (sel == D1)),
    .count  (count_d1)
  );

endmodule

// File: tb/tb_drenaje_salidas.sv
// tb/tb_drenaje_salidas.sv - randomized and directed checks of drenaje_salidas against a queue-based model
module tb_drenaje_salidas;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       empty_d0 = 1'b1;
  logic       empty_d1 = 1'b1;
  logic [5:0] data_out0 = '0;
  logic [5:0] data_out1 = '0;
  logic       pop_D0, pop_D1;
  logic [5:0] out_data;
  logic       out_src;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] count_d0, count_d1;
  logic       misroute_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [6:0] exp_q[$];
  int         tally0 = 0;
  int         tally1 = 0;
  logic       exp_mis = 1'b0;
  logic       model_last = 1'b1;

  drenaje_salidas dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .empty_d0     (empty_d0),
    .empty_d1     (empty_d1),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .pop_D0       (pop_D0),
    .pop_D1       (pop_D1),
    .out_data     (out_data),
    .out_src      (out_src),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count_d0     (count_d0),
    .count_d1     (count_d1),
    .misroute_err (misroute_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // FIFO model: registered read data one cycle after the pop.
  always @(posedge clk) begin
    if (pop_D0) begin
      chk("pop_d0_nonempty", (q0.size() != 0), 1);
      if (q0.size() != 0) data_out0 <= q0.pop_front();
    end
    if (pop_D1) begin
      chk("pop_d1_nonempty", (q1.size() != 0), 1);
      if (q1.size() != 0) data_out1 <= q1.pop_front();
    end
  end

  always @(negedge clk) begin
    empty_d0 = (q0.size() == 0);
    empty_d1 = (q1.size() == 0);
  end

  // Scoreboard: every transfer must match the next expected word, counts and flag.
  always @(negedge clk) begin
    logic [6:0] e;
    if (reset) begin
      chk("pop_exclusive", {31'd0, pop_D0 & pop_D1}, 0);
      if (pop_D0 || pop_D1) chk("pop_while_valid", {31'd0, out_valid}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {25'd0, out_src, out_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {26'd0, out_data}, {26'd0, e[5:0]});
          chk("out_src", {31'd0, out_src}, {31'd0, e[6]});
          if (e[6]) tally1 = (tally1 < 255) ? tally1 + 1 : 255;
          else      tally0 = (tally0 < 255) ? tally0 + 1 : 255;
          if (e[4] != e[6]) exp_mis = 1'b1;
          model_last = e[6];
          chk("count_d0", {24'd0, count_d0}, tally0);
          chk("count_d1", {24'd0, count_d1}, tally1);
          chk("misroute_err", {31'd0, misroute_err}, {31'd0, exp_mis});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_dut(input int n);
    reset = 1'b0;
    exp_q.delete();
    tally0 = 0;
    tally1 = 0;
    exp_mis = 1'b0;
    model_last = 1'b1;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  // Expected order from the queue contents: alternate when both have data.
  task automatic build_exp;
    logic [5:0] c0[$];
    logic [5:0] c1[$];
    logic       last, s;
    c0 = q0;
    c1 = q1;
    last = model_last;
    while (c0.size() != 0 || c1.size() != 0) begin
      if (c0.size() != 0 && c1.size() != 0) s = ~last;
      else s = (c0.size() == 0);
      if (s) exp_q.push_back({1'b1, c1.pop_front()});
      else   exp_q.push_back({1'b0, c0.pop_front()});
      last = s;
    end
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 && !out_valid) && n < budget) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 4) != 0);
      end
      tick();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
    out_ready = 1'b1;
    enable    = 1'b1;
    repeat (2) tick();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("valid_timeout", 0, 1);
  endtask

  function automatic logic [5:0] rword(input logic s);
    logic [5:0] w;
    w = 6'($urandom_range(0, 63));
    if ($urandom_range(0, 7) != 0) w[4] = s;
    return w;
  endfunction

  initial begin
    int pops[$];
    int vcyc;
    logic [5:0] held;

    // Reset held with D0 non-empty: nothing may move.
    q0.push_back(6'h05); q0.push_back(6'h06); q0.push_back(6'h07);
    reset = 1'b0;
    repeat (4) begin
      tick();
      chk("rst_pops", {30'd0, pop_D0, pop_D1}, 0);
      chk("rst_out", {24'd0, out_valid, out_src, out_data}, 0);
      chk("rst_counts", {16'd0, count_d0, count_d1}, 0);
      chk("rst_mis", {31'd0, misroute_err}, 0);
    end
    build_exp();
    reset = 1'b1;
    vcyc = -1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pop_D0) pops.push_back(cyc);
      if (out_valid && vcyc < 0) vcyc = cyc;
    end
    chk("d0_pop_count", pops.size(), 3);
    if (pops.size() == 3) begin
      chk("pop_spacing_1", pops[1] - pops[0], 4);
      chk("pop_spacing_2", pops[2] - pops[1], 4);
      chk("latency", vcyc - pops[0], 2);
    end
    wait_idle(40, 0);
    chk("d0_only_cnt0", {24'd0, count_d0}, 3);
    chk("d0_only_cnt1", {24'd0, count_d1}, 0);

    // Both FIFOs loaded: D0 served first after reset, then alternating.
    reset_dut(2);
    q0.push_back(6'h01); q0.push_back(6'h02);
    q1.push_back(6'h11); q1.push_back(6'h12);
    build_exp();
    chk("rr_first", {25'd0, exp_q[0]}, {25'd0, 7'h01});
    wait_idle(60, 0);

    // Back-pressure: word held, no pops while out_ready is low.
    out_ready = 1'b0;
    q0.push_back(6'h03); q0.push_back(6'h04);
    build_exp();
    wait_valid(20);
    held = out_data;
    chk("hold_first", {26'd0, held}, 32'h03);
    repeat (10) begin
      tick();
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_data", {26'd0, out_data}, {26'd0, held});
      chk("hold_nopop", {30'd0, pop_D0, pop_D1}, 0);
    end
    out_ready = 1'b1;
    wait_idle(40, 0);

    // Misroute: D0 word with destination bit set.
    chk("mis_before", {31'd0, misroute_err}, 0);
    q0.push_back(6'h10);
    build_exp();
    out_ready = 1'b0;
    wait_valid(20);
    chk("mis_rise", {31'd0, misroute_err}, 1);
    out_ready = 1'b1;
    wait_idle(20, 0);
    q0.push_back(6'h01);
    build_exp();
    wait_idle(20, 0);
    chk("mis_sticky", {31'd0, misroute_err}, 1);
    reset_dut(2);
    chk("mis_cleared", {31'd0, misroute_err}, 0);

    // Reset during READ: the popped word is lost, the next one comes through.
    q0.push_back(6'h21); q0.push_back(6'h22);
    begin
      int n = 0;
      while (!pop_D0 && n < 20) begin tick(); n++; end
      if (n >= 20) chk("read_timeout", 0, 1);
    end
    reset = 1'b0;
    exp_q.delete(); tally0 = 0; tally1 = 0; exp_mis = 1'b0; model_last = 1'b1;
    tick();
    reset = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 0);
    chk("midrst_counts", {16'd0, count_d0, count_d1}, 0);
    chk("midrst_fifo", q0.size(), 1);
    build_exp();
    wait_idle(30, 0);
    chk("midrst_next_cnt", {24'd0, count_d0}, 1);

    // Randomized rounds with random enable / out_ready.
    for (int r = 0; r < 6; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 10);
      n1 = $urandom_range(0, 10);
      for (int i = 0; i < n0; i++) q0.push_back(rword(1'b0));
      for (int i = 0; i < n1; i++) q1.push_back(rword(1'b1));
      build_exp();
      wait_idle(800, 1);
    end

    // Counter saturation.
    reset_dut(2);
    for (int i = 0; i < 258; i++) begin
      logic [5:0] w;
      w = rword(1'b0);
      w[4] = 1'b0;
      q0.push_back(w);
    end
    build_exp();
    wait_idle(258 * 4 + 100, 0);
    chk("count_sat", {24'd0, count_d0}, 255);
    chk("count_sat_d1", {24'd0, count_d1}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
